snd_status_conditioner: RTL

- Input-conditioning stage directly upstream of the sound-FPGA status PIO; its status_out drives the PIO's 5-bit in_port.
- Synchronises the raw asynchronous status lines from the sound FPGA into clk, debounces each bit independently, and reports only clean levels.
- Also produces per-bit change strobes and a sticky per-bit event register, so software can detect short status transitions between polls.

---
 rtl/snd_status_pkg.sv | 16 +
 rtl/snd_status_debounce_bit.sv | 63 ++++++
 rtl/snd_status_conditioner.sv | 67 ++++++
 3 files changed

// File: rtl/snd_status_pkg.sv
// Shared constants for the sound-FPGA status conditioner: line count,
// default timing and the index of each status line.
package snd_status_pkg;

  localparam int unsigned SND_STATUS_WIDTH            = 5;
  localparam int unsigned SND_STATUS_DEBOUNCE_DEFAULT = 50000;
  localparam int unsigned SND_STATUS_SYNC_DEFAULT     = 2;

  // Bit positions of the individual status lines within raw_in/status_out.
  localparam int unsigned SND_STAT_READY   = 0;
  localparam int unsigned SND_STAT_BUSY    = 1;
  localparam int unsigned SND_STAT_PLAYING = 2;
  localparam int unsigned SND_STAT_ERROR   = 3;
  localparam int unsigned SND_STAT_IRQ     = 4;

endpackage

// File: rtl/snd_status_debounce_bit.sv
// One status line: SYNC_STAGES-deep synchroniser, debounce counter,
// stable level flop and a registered one-cycle toggle strobe.
module snd_status_debounce_bit
  import snd_status_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = SND_STATUS_DEBOUNCE_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SND_STATUS_SYNC_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_in,
  output logic stable_out,
  output logic strb_out,
  output logic toggle_next
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   strb_q, strb_d;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // The counter only runs while the synchronised level disagrees with the
  // stable level, and is cleared on the edge that adopts the new level.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in};
    cnt_d    = '0;
    stable_d = stable_q;
    strb_d   = 1'b0;
    if (sync_bit != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_bit;
        strb_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      strb_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      strb_q   <= strb_d;
    end
  end

  assign stable_out  = stable_q;
  assign strb_out    = strb_q;
  assign toggle_next = strb_d;

endmodule

// File: rtl/snd_status_conditioner.sv
// Conditions the raw sound-FPGA status lines for the status PIO in_port.
// Sticky event register is built only with SND_STATUS_EVENT_LATCH_EN defined.
module snd_status_conditioner
  import snd_status_pkg::*;
#(
  parameter int unsigned WIDTH           = SND_STATUS_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = SND_STATUS_DEBOUNCE_DEFAULT,
  parameter int unsigned SYNC_STAGES     = SND_STATUS_SYNC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] status_out,
  output logic [WIDTH-1:0] change_strb,
  output logic [WIDTH-1:0] event_bits,
  output logic             event_pending
);

  logic [WIDTH-1:0] strb_next;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    snd_status_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_bit (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw_in     (raw_in[g]),
      .stable_out (status_out[g]),
      .strb_out   (change_strb[g]),
      .toggle_next(strb_next[g])
    );
  end

`ifdef SND_STATUS_EVENT_LATCH_EN
  logic [WIDTH-1:0] event_bits_q, event_bits_d;
  logic             event_pending_q, event_pending_d;

  // Set uses the strobe's next value so the event lands on the same edge
  // as change_strb; OR-ing it in after the clear makes set win.
  always_comb begin
    event_bits_d    = (event_bits_q & ~clr_mask) | strb_next;
    event_pending_d = |event_bits_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_bits_q    <= '0;
      event_pending_q <= 1'b0;
    end else begin
      event_bits_q    <= event_bits_d;
      event_pending_q <= event_pending_d;
    end
  end

  assign event_bits    = event_bits_q;
  assign event_pending = event_pending_q;
`else
  logic unused_event_inputs;

  assign unused_event_inputs = ^{clr_mask, strb_next};
  assign event_bits          = '0;
  assign event_pending       = 1'b0;
`endif

endmodule
